// File: rtl/unpacker_arb_if.sv
// Bundles the per-source request channels and the unpacker-facing beat channel.
// master is the arbiter's view; slave is the view of the sources and unpacker around it.
interface unpacker_arb_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 1280,
    parameter int VBC_W  = 8
);
    logic [N_REQ-1:0]        req_val;
    logic [N_REQ-1:0]        req_sop;
    logic [N_REQ-1:0]        req_eop;
    logic [N_REQ*VBC_W-1:0]  req_vbc;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    u_val;
    logic                    u_sop;
    logic                    u_eop;
    logic [VBC_W-1:0]        u_vbc;
    logic [DATA_W-1:0]       u_data;
    logic                    u_ready;

    modport master (
        input  req_val, req_sop, req_eop, req_vbc, req_data,
        output req_ready,
        output u_val, u_sop, u_eop, u_vbc, u_data,
        input  u_ready
    );

    modport slave (
        output req_val, req_sop, req_eop, req_vbc, req_data,
        input  req_ready,
        input  u_val, u_sop, u_eop, u_vbc, u_data,
        output u_ready
    );
endinterface

// File: rtl/unpacker_arb.sv
// Round-robin packet arbiter feeding a single unpacker from N_REQ sources.
// Grants only at packet boundaries and enforces cfg_gap idle cycles after each eop.
module unpacker_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 1280,
    parameter int VBC_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [3:0]           cfg_gap,
    unpacker_arb_if.master       bus,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic                 err_sop,
    output logic [15:0]          pkt_cnt
);
    localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]   N_L     = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_L  = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [3:0]         r_gap_cnt;
    logic [15:0]        r_pkt_cnt;
    logic               r_first;
    logic               r_busy;

    logic               w_u_val;
    logic               w_u_sop;
    logic               w_u_eop;
    logic [VBC_W-1:0]   w_u_vbc;
    logic [DATA_W-1:0]  w_u_data;
    logic               w_xfer;
    logic [N_REQ-1:0]   w_elig;
    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W:0]     w_idx;

    // Forward the granted source; r_gnt is one-hot or zero so OR-reduction is a clean mux.
    always_comb begin
        w_u_val  = 1'b0;
        w_u_sop  = 1'b0;
        w_u_eop  = 1'b0;
        w_u_vbc  = {VBC_W{1'b0}};
        w_u_data = {DATA_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            w_u_val  = w_u_val | (r_gnt[i] & bus.req_val[i]);
            w_u_sop  = w_u_sop | (r_gnt[i] & bus.req_sop[i]);
            w_u_eop  = w_u_eop | (r_gnt[i] & bus.req_eop[i]);
            w_u_vbc  = w_u_vbc  | ({VBC_W{r_gnt[i]}}  & bus.req_vbc[i*VBC_W +: VBC_W]);
            w_u_data = w_u_data | ({DATA_W{r_gnt[i]}} & bus.req_data[i*DATA_W +: DATA_W]);
        end
    end

    assign w_xfer        = w_u_val & bus.u_ready;
    assign bus.u_val     = w_u_val;
    assign bus.u_sop     = w_u_sop;
    assign bus.u_eop     = w_u_eop;
    assign bus.u_vbc     = w_u_vbc;
    assign bus.u_data    = w_u_data;
    assign bus.req_ready = r_gnt & {N_REQ{bus.u_ready}};

    // Search eligible sources starting at rr_ptr, wrapping at N_REQ.
    always_comb begin
        w_elig  = bus.req_val & bus.req_sop;
        w_found = 1'b0;
        w_win   = {PTR_W{1'b0}};
        w_sum   = {(PTR_W+1){1'b0}};
        w_idx   = {(PTR_W+1){1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            w_idx = (w_sum >= N_L) ? (w_sum - N_L) : w_sum;
            if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PTR_W-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Arbitration / transfer / gap state machine with registered status outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state   <= ST_IDLE;
            r_gnt     <= {N_REQ{1'b0}};
            r_rr_ptr  <= {PTR_W{1'b0}};
            r_gap_cnt <= 4'd0;
            r_pkt_cnt <= 16'd0;
            r_first   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state  <= ST_BUSY;
                        r_gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
                        r_rr_ptr <= (w_win == LAST_L) ? {PTR_W{1'b0}} : (w_win + PTR_W'(1));
                        r_first  <= 1'b1;
                        r_busy   <= 1'b1;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (w_xfer) begin
                        r_first <= 1'b0;
                        if (w_u_eop) begin
                            r_pkt_cnt <= r_pkt_cnt + 16'd1;
                            r_gnt     <= {N_REQ{1'b0}};
                            if (cfg_gap == 4'd0) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= cfg_gap;
                            end
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt <= 4'd1) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= 4'd0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= {N_REQ{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A sop seen after the first beat of a granted packet is flagged on that transfer.
    assign err_sop = w_xfer & w_u_sop & ~r_first;
    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign pkt_cnt = r_pkt_cnt;
endmodule

// File: tb/tb_unpacker_arb.sv
// Directed table-driven bench for unpacker_arb plus hand sequences for gap timing and async reset.
module tb_unpacker_arb;
    localparam int N  = 4;
    localparam int DW = 1280;
    localparam int VW = 8;

    logic        clk;
    logic        reset_L;
    logic [3:0]  cfg_gap;
    logic [N-1:0] gnt;
    logic        busy;
    logic        err_sop;
    logic [15:0] pkt_cnt;

    int n_cmp;
    int n_fail;

    unpacker_arb_if #(.N_REQ(N), .DATA_W(DW), .VBC_W(VW)) bus ();

    unpacker_arb #(.N_REQ(N), .DATA_W(DW), .VBC_W(VW)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .cfg_gap (cfg_gap),
        .bus     (bus),
        .gnt     (gnt),
        .busy    (busy),
        .err_sop (err_sop),
        .pkt_cnt (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  val;
        logic [3:0]  sop;
        logic [3:0]  eop;
        logic        ur;
        logic [7:0]  vbc;
        logic [7:0]  tag;
        logic [3:0]  gnt;
        logic        busy;
        logic        err;
        logic [15:0] pkt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic [3:0] val, input logic [3:0] sop, input logic [3:0] eop,
                                 input logic ur, input logic [7:0] vbc, input logic [7:0] tag,
                                 input logic [3:0] g, input logic b, input logic e, input logic [15:0] p);
        vec_t v;
        v.val = val; v.sop = sop; v.eop = eop; v.ur = ur; v.vbc = vbc; v.tag = tag;
        v.gnt = g; v.busy = b; v.err = e; v.pkt = p;
        return v;
    endfunction

    function automatic logic [DW-1:0] mk_data(input int src, input logic [7:0] tag);
        logic [31:0] w;
        w = {8'(src), tag, 16'hC0DE};
        return {40{w}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ..%016h expected ..%016h", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic drive(input logic [3:0] val, input logic [3:0] sop, input logic [3:0] eop,
                         input logic ur, input logic [7:0] vbc, input logic [7:0] tag);
        bus.req_val = val;
        bus.req_sop = sop;
        bus.req_eop = eop;
        bus.u_ready = ur;
        for (int i = 0; i < N; i++) begin
            bus.req_vbc[i*VW +: VW]  = vbc + 8'(i);
            bus.req_data[i*DW +: DW] = mk_data(i, tag);
        end
    endtask

    // Expected forwarded beat is whatever the expected granted source is presenting.
    task automatic check_exp(input string nm, input vec_t v);
        int src;
        logic ev, es, ee;
        logic [7:0] evbc;
        logic [DW-1:0] ed;
        src = 0;
        for (int i = 0; i < N; i++) if (v.gnt[i]) src = i;
        if (v.gnt != 4'd0) begin
            ev = v.val[src]; es = v.sop[src]; ee = v.eop[src];
            evbc = v.vbc + 8'(src); ed = mk_data(src, v.tag);
        end else begin
            ev = 1'b0; es = 1'b0; ee = 1'b0; evbc = 8'd0; ed = '0;
        end
        chk({nm, " gnt"},       64'(gnt),           64'(v.gnt));
        chk({nm, " busy"},      64'(busy),          64'(v.busy));
        chk({nm, " err_sop"},   64'(err_sop),       64'(v.err));
        chk({nm, " pkt_cnt"},   64'(pkt_cnt),       64'(v.pkt));
        chk({nm, " req_ready"}, 64'(bus.req_ready), 64'(v.gnt & {4{v.ur}}));
        chk({nm, " u_val"},     64'(bus.u_val),     64'(ev));
        chk({nm, " u_sop"},     64'(bus.u_sop),     64'(es));
        chk({nm, " u_eop"},     64'(bus.u_eop),     64'(ee));
        chk({nm, " u_vbc"},     64'(bus.u_vbc),     64'(evbc));
        chk_data({nm, " u_data"}, bus.u_data, ed);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_dist;
        int n_gap;
        int n_bad;
        int n_busy;
        n_cmp = 0;
        n_fail = 0;
        cfg_gap = 4'd0;
        reset_L = 1'b0;
        drive(4'hF, 4'h0, 4'h0, 1'b1, 8'd0, 8'd0);

        // Reset state: outputs quiet even with sources asserting val
        @(negedge clk);
        check_exp("reset", mkv(4'hF, 4'h0, 4'h0, 1'b1, 8'd0, 8'd0, 4'h0, 1'b0, 1'b0, 16'd0));
        drive(4'h0, 4'h0, 4'h0, 1'b1, 8'd0, 8'd0);
        @(negedge clk);
        reset_L = 1'b1;
        step();

        // All four sources with continuous 1-beat packets: rotation 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mkv(4'hF, 4'hF, 4'hF, 1'b1, 8'd10, 8'd0, 4'h0, 1'b0, 1'b0, 16'(k)));
            tbl.push_back(mkv(4'hF, 4'hF, 4'hF, 1'b1, 8'd10, 8'd0, 4'(1 << (k % 4)), 1'b1, 1'b0, 16'(k)));
        end
        // src0 three-beat packet, vbc 160,160,64
        tbl.push_back(mkv(4'h1, 4'h1, 4'h0, 1'b1, 8'd160, 8'd0, 4'h0, 1'b0, 1'b0, 16'd5));
        tbl.push_back(mkv(4'h1, 4'h1, 4'h0, 1'b1, 8'd160, 8'd0, 4'h1, 1'b1, 1'b0, 16'd5));
        tbl.push_back(mkv(4'h1, 4'h0, 4'h0, 1'b1, 8'd160, 8'd1, 4'h1, 1'b1, 1'b0, 16'd5));
        tbl.push_back(mkv(4'h1, 4'h0, 4'h1, 1'b1, 8'd64,  8'd2, 4'h1, 1'b1, 1'b0, 16'd5));
        tbl.push_back(mkv(4'h0, 4'h0, 4'h0, 1'b1, 8'd0,   8'd0, 4'h0, 1'b0, 1'b0, 16'd6));
        // val without sop in IDLE is never granted
        tbl.push_back(mkv(4'h4, 4'h0, 4'h0, 1'b1, 8'd0,   8'd0, 4'h0, 1'b0, 1'b0, 16'd6));
        tbl.push_back(mkv(4'h4, 4'h0, 4'h0, 1'b1, 8'd0,   8'd0, 4'h0, 1'b0, 1'b0, 16'd6));
        // src3: val gap mid-packet, then sop on beat 2 of 3
        tbl.push_back(mkv(4'h8, 4'h8, 4'h0, 1'b1, 8'd100, 8'd0, 4'h0, 1'b0, 1'b0, 16'd6));
        tbl.push_back(mkv(4'h8, 4'h8, 4'h0, 1'b1, 8'd100, 8'd0, 4'h8, 1'b1, 1'b0, 16'd6));
        tbl.push_back(mkv(4'h0, 4'h0, 4'h0, 1'b1, 8'd100, 8'd0, 4'h8, 1'b1, 1'b0, 16'd6));
        tbl.push_back(mkv(4'h8, 4'h8, 4'h0, 1'b1, 8'd100, 8'd1, 4'h8, 1'b1, 1'b1, 16'd6));
        tbl.push_back(mkv(4'h8, 4'h0, 4'h8, 1'b1, 8'd100, 8'd2, 4'h8, 1'b1, 1'b0, 16'd6));
        tbl.push_back(mkv(4'h0, 4'h0, 4'h0, 1'b1, 8'd0,   8'd0, 4'h0, 1'b0, 1'b0, 16'd7));
        // src1 two-beat packet with u_ready 1,0,0,1
        tbl.push_back(mkv(4'h2, 4'h2, 4'h0, 1'b1, 8'd50,  8'd0, 4'h0, 1'b0, 1'b0, 16'd7));
        tbl.push_back(mkv(4'h2, 4'h2, 4'h0, 1'b1, 8'd50,  8'd0, 4'h2, 1'b1, 1'b0, 16'd7));
        tbl.push_back(mkv(4'h2, 4'h0, 4'h2, 1'b0, 8'd50,  8'd1, 4'h2, 1'b1, 1'b0, 16'd7));
        tbl.push_back(mkv(4'h2, 4'h0, 4'h2, 1'b0, 8'd50,  8'd1, 4'h2, 1'b1, 1'b0, 16'd7));
        tbl.push_back(mkv(4'h2, 4'h0, 4'h2, 1'b1, 8'd50,  8'd1, 4'h2, 1'b1, 1'b0, 16'd7));
        tbl.push_back(mkv(4'h0, 4'h0, 4'h0, 1'b1, 8'd0,   8'd0, 4'h0, 1'b0, 1'b0, 16'd8));

        foreach (tbl[r]) begin
            drive(tbl[r].val, tbl[r].sop, tbl[r].eop, tbl[r].ur, tbl[r].vbc, tbl[r].tag);
            @(negedge clk);
            check_exp($sformatf("row%0d", r), tbl[r]);
            step();
        end

        // Async reset in the middle of a src2 packet; rr_ptr must return to 0
        drive(4'h4, 4'h4, 4'h0, 1'b1, 8'd20, 8'd0);
        step();
        @(negedge clk);
        check_exp("rst_pre", mkv(4'h4, 4'h4, 4'h0, 1'b1, 8'd20, 8'd0, 4'h4, 1'b1, 1'b0, 16'd8));
        #2;
        reset_L = 1'b0;
        #1;
        check_exp("rst_async", mkv(4'h4, 4'h4, 4'h0, 1'b1, 8'd20, 8'd0, 4'h0, 1'b0, 1'b0, 16'd0));
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        drive(4'h9, 4'h9, 4'h9, 1'b1, 8'd30, 8'd0);
        step();
        @(negedge clk);
        check_exp("rst_win", mkv(4'h9, 4'h9, 4'h9, 1'b1, 8'd30, 8'd0, 4'h1, 1'b1, 1'b0, 16'd0));
        step();
        drive(4'h0, 4'h0, 4'h0, 1'b1, 8'd0, 8'd0);
        @(negedge clk);
        check_exp("rst_done", mkv(4'h0, 4'h0, 4'h0, 1'b1, 8'd0, 8'd0, 4'h0, 1'b0, 1'b0, 16'd1));
        step();

        // cfg_gap=5 between src1 and src2; cfg_gap changed after eop must not matter
        cfg_gap = 4'd5;
        drive(4'h6, 4'h6, 4'h6, 1'b1, 8'd40, 8'd0);
        step();
        @(negedge clk);
        check_exp("gap_src1", mkv(4'h6, 4'h6, 4'h6, 1'b1, 8'd40, 8'd0, 4'h2, 1'b1, 1'b0, 16'd1));
        step();
        drive(4'h4, 4'h4, 4'h4, 1'b1, 8'd40, 8'd0);
        cfg_gap = 4'd2;
        n_dist = 0;
        n_gap = 0;
        n_bad = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.u_val) begin
                n_dist = c;
                break;
            end
            if (busy) n_gap++;
            if (bus.req_ready != 4'h0 || gnt != 4'h0) n_bad++;
            step();
        end
        chk("gap eop_to_val", 64'(n_dist), 64'd7);
        chk("gap busy_cycles", 64'(n_gap), 64'd5);
        chk("gap quiet", 64'(n_bad), 64'd0);
        check_exp("gap_src2", mkv(4'h4, 4'h4, 4'h4, 1'b1, 8'd40, 8'd0, 4'h4, 1'b1, 1'b0, 16'd2));
        step();
        drive(4'h0, 4'h0, 4'h0, 1'b1, 8'd0, 8'd0);
        n_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) break;
            n_busy++;
            step();
        end
        chk("gap2 busy_cycles", 64'(n_busy), 64'd2);
        chk("gap2 pkt_cnt", 64'(pkt_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
